// File: rtl/spam_console_fifo_pkg.sv
// Shared SPAM bus constants, console register map and status layout.
// Imported by the console FIFO interface, byte FIFO and top level.
package spam_console_fifo_pkg;

  localparam int SPAM_DID_HI  = 3;
  localparam int SPAM_ADDR_HI = 15;
  localparam int SPAM_DATA_HI = 31;

  localparam logic [SPAM_DID_HI:0] SPAM_DID_CONSOLE = 4'h2;

  localparam logic [1:0] SPAM_CIO_REG_DATA   = 2'd0;
  localparam logic [1:0] SPAM_CIO_REG_STATUS = 2'd1;

  typedef enum logic [1:0] {
    REG_DATA   = SPAM_CIO_REG_DATA,
    REG_STATUS = SPAM_CIO_REG_STATUS,
    REG_RSVD2  = 2'd2,
    REG_RSVD3  = 2'd3
  } cio_reg_e;

  typedef struct packed {
    logic       rx_ovf;
    logic       tx_ovf;
    logic       tx_full;
    logic       rx_empty;
    logic [7:0] tx_cnt;
    logic [7:0] rx_cnt;
  } cio_status_t;

  // A 256-deep FIFO reads back 255 when full; tx_full tells them apart.
  function automatic logic [7:0] cnt8(input logic [8:0] c);
    return c[8] ? 8'hFF : c[7:0];
  endfunction

endpackage

// File: rtl/spam_console_fifo_if.sv
// SPAM request/response plus system-side byte streams of the console.
// slave = console device, master = CPU bus and terminal side.
interface spam_console_fifo_if;
  import spam_console_fifo_pkg::*;

  logic                  spamo_valid;
  logic                  spamo_r_nw;
  logic [SPAM_DID_HI:0]  spamo_did;
  logic [SPAM_ADDR_HI:0] spamo_addr;
  logic [SPAM_DATA_HI:0] spamo_data;
  logic                  cio__spami_busy_b;
  logic [SPAM_DATA_HI:0] cio__spami_data;
  logic [7:0]            sys_tx_data;
  logic                  sys_tx_valid;
  logic                  sys_tx_ready;
  logic [7:0]            sys_rx_data;
  logic                  sys_rx_valid;
  logic                  sys_rx_ready;

  modport slave (
    input  spamo_valid, spamo_r_nw, spamo_did,
    input  spamo_addr, spamo_data,
    output cio__spami_busy_b, cio__spami_data,
    output sys_tx_data, sys_tx_valid,
    input  sys_tx_ready,
    input  sys_rx_data, sys_rx_valid,
    output sys_rx_ready
  );

  modport master (
    output spamo_valid, spamo_r_nw, spamo_did,
    output spamo_addr, spamo_data,
    input  cio__spami_busy_b, cio__spami_data,
    input  sys_tx_data, sys_tx_valid,
    output sys_tx_ready,
    output sys_rx_data, sys_rx_valid,
    input  sys_rx_ready
  );

endinterface

// File: rtl/spam_console_fifo_byte_fifo.sv
// Byte FIFO with registered count and combinational head data.
// Push into a full FIFO succeeds only alongside a valid pop.
module spam_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  output logic [7:0]    o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int AW = CW - 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  logic w_pop;
  logic w_push;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rd];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/spam_console_fifo.sv
// SPAM console slave: TX/RX byte FIFOs, status/control, sticky overflows.
// Responses are registered one cycle after the request edge.
module spam_console_fifo
  import spam_console_fifo_pkg::*;
#(
  parameter int                   DEPTH = 16,
  parameter logic [SPAM_DID_HI:0] DID   = SPAM_DID_CONSOLE,
  parameter int                   CW    = $clog2(DEPTH) + 1
) (
  input logic                clk,
  input logic                rst_b,
  spam_console_fifo_if.slave bus
);

  logic          w_sel;
  cio_reg_e      w_idx;
  logic          w_wr_data;
  logic          w_rd_data;
  logic          w_wr_ctrl;
  logic          w_tx_pop;
  logic          w_rx_push;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic [CW-1:0] w_tx_cnt;
  logic [CW-1:0] w_rx_cnt;
  logic [7:0]    w_rx_head;
  logic [31:0]   w_rdata;
  cio_status_t   w_stat;
  logic          w_unused;

  logic          r_run;
  logic          r_tx_ovf;
  logic          r_rx_ovf;
  logic          r_busy_b;
  logic [31:0]   r_data;

  assign w_sel     = bus.spamo_valid && (bus.spamo_did == DID);
  assign w_idx     = cio_reg_e'(bus.spamo_addr[3:2]);
  assign w_wr_data = w_sel && !bus.spamo_r_nw && (w_idx == REG_DATA);
  assign w_rd_data = w_sel && bus.spamo_r_nw && (w_idx == REG_DATA);
  assign w_wr_ctrl = w_sel && !bus.spamo_r_nw && (w_idx == REG_STATUS);

  assign bus.sys_tx_valid = !w_tx_empty;
  assign bus.sys_rx_ready = r_run && !w_rx_full;

  assign w_tx_pop  = bus.sys_tx_valid && bus.sys_tx_ready;
  assign w_rx_push = bus.sys_rx_valid && bus.sys_rx_ready;

  assign w_unused = &{1'b0, bus.spamo_addr[SPAM_ADDR_HI:4],
                      bus.spamo_addr[1:0], bus.spamo_data[SPAM_DATA_HI:8]};

  spam_byte_fifo #(.DEPTH(DEPTH), .CW(CW)) u_tx (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_push  (w_wr_data),
    .i_data  (bus.spamo_data[7:0]),
    .i_pop   (w_tx_pop),
    .o_data  (bus.sys_tx_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_cnt)
  );

  spam_byte_fifo #(.DEPTH(DEPTH), .CW(CW)) u_rx (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_push  (w_rx_push),
    .i_data  (bus.sys_rx_data),
    .i_pop   (w_rd_data),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_cnt)
  );

  always_comb begin
    w_stat          = '0;
    w_stat.rx_cnt   = cnt8(9'(w_rx_cnt));
    w_stat.tx_cnt   = cnt8(9'(w_tx_cnt));
    w_stat.rx_empty = w_rx_empty;
    w_stat.tx_full  = w_tx_full;
    w_stat.tx_ovf   = r_tx_ovf;
    w_stat.rx_ovf   = r_rx_ovf;
  end

  always_comb begin
    w_rdata = '0;
    unique case (w_idx)
      REG_DATA:   w_rdata = w_rx_empty ? 32'h0 : {23'h0, 1'b1, w_rx_head};
      REG_STATUS: w_rdata = {12'h0, w_stat};
      REG_RSVD2:  w_rdata = '0;
      REG_RSVD3:  w_rdata = '0;
    endcase
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_run    <= 1'b0;
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
      r_busy_b <= 1'b0;
      r_data   <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_wr_data && w_tx_full && !w_tx_pop)
        r_tx_ovf <= 1'b1;
      else if (w_wr_ctrl && bus.spamo_data[0])
        r_tx_ovf <= 1'b0;
      if (bus.sys_rx_valid && !bus.sys_rx_ready)
        r_rx_ovf <= 1'b1;
      else if (w_wr_ctrl && bus.spamo_data[0])
        r_rx_ovf <= 1'b0;
      r_busy_b <= w_sel;
      r_data   <= (w_sel && bus.spamo_r_nw) ? w_rdata : '0;
    end
  end

  assign bus.cio__spami_busy_b = r_busy_b;
  assign bus.cio__spami_data   = r_data;

endmodule

// File: tb/tb_spam_console_fifo.sv
// Scoreboard bench for spam_console_fifo (DEPTH 16).
// Expected bytes are queued at stimulus time and popped on DUT output.
module tb_spam_console_fifo;
  import spam_console_fifo_pkg::*;

  localparam logic [3:0]  DIDC = SPAM_DID_CONSOLE;
  localparam logic [15:0] A_DATA = 16'h0000;
  localparam logic [15:0] A_STAT = 16'h0004;
  localparam logic [15:0] A_R2   = 16'h0008;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  spam_console_fifo_if bus ();

  spam_console_fifo #(.DEPTH(16)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_b && bus.sys_rx_valid && bus.sys_rx_ready)
      rxq.push_back(bus.sys_rx_data);

  task automatic spam(input bit rnw, input logic [3:0] did,
                      input logic [15:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic bb);
    @(negedge clk);
    bus.spamo_valid = 1'b1;
    bus.spamo_r_nw  = rnw;
    bus.spamo_did   = did;
    bus.spamo_addr  = addr;
    bus.spamo_data  = wd;
    @(posedge clk);
    #1;
    rd = bus.cio__spami_data;
    bb = bus.cio__spami_busy_b;
    bus.spamo_valid = 1'b0;
  endtask

  task automatic wr_tx(input logic [7:0] b, input bit track);
    logic [31:0] d;
    logic bb;
    spam(1'b0, DIDC, A_DATA, {24'h0, b}, d, bb);
    if (track) txq.push_back(b);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic bb;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.sys_rx_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL rst_rx_ready got %b want 0", bus.sys_rx_ready);
    end
    n_cmp++;
    if (bus.cio__spami_busy_b !== 1'b0 || bus.cio__spami_data !== 32'h0) begin
      n_mis++;
      $display("FAIL rst_resp got %b/%h want 0/0",
               bus.cio__spami_busy_b, bus.cio__spami_data);
    end
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.sys_rx_ready !== 1'b1 || bus.sys_tx_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL rst_out rdy/vld got %b/%b want 1/0",
               bus.sys_rx_ready, bus.sys_tx_valid);
    end
    spam(1'b1, DIDC, A_STAT, 32'h0, d, bb);
    n_cmp++;
    if (d !== 32'h0001_0000 || bb !== 1'b1) begin
      n_mis++;
      $display("FAIL rst_status got %h/%b want 00010000/1", d, bb);
    end
  endtask

  task automatic drain_tx(input string tag);
    @(negedge clk);
    bus.sys_tx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!bus.sys_tx_valid) break;
      n_cmp++;
      if (txq.size() == 0) begin
        n_mis++;
        $display("FAIL %s_extra got %h want none", tag, bus.sys_tx_data);
      end else begin
        logic [7:0] e;
        e = txq.pop_front();
        if (bus.sys_tx_data !== e) begin
          n_mis++;
          $display("FAIL %s_byte got %h want %h", tag, bus.sys_tx_data, e);
        end
      end
      @(negedge clk);
    end
    bus.sys_tx_ready = 1'b0;
    n_cmp++;
    if (txq.size() != 0 || bus.sys_tx_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL %s_left got %0d/%b want 0/0", tag, txq.size(),
               bus.sys_tx_valid);
    end
    txq.delete();
  endtask

  task automatic test_tx_basic();
    logic [31:0] d;
    logic bb;
    bus.sys_tx_ready = 1'b0;
    wr_tx(8'h41, 1'b1);
    wr_tx(8'h42, 1'b1);
    spam(1'b1, DIDC, A_STAT, 32'h0, d, bb);
    n_cmp++;
    if (d !== 32'h0001_0200) begin
      n_mis++;
      $display("FAIL tx2_status got %h want 00010200", d);
    end
    drain_tx("tx2");
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    logic bb;
    for (int i = 0; i < 17; i++)
      wr_tx(8'h10 + 8'(i), i < 16);
    spam(1'b1, DIDC, A_STAT, 32'h0, d, bb);
    n_cmp++;
    if (d !== 32'h0007_1000) begin
      n_mis++;
      $display("FAIL txovf_status got %h want 00071000", d);
    end
    drain_tx("txovf");
    spam(1'b0, DIDC, A_STAT, 32'h1, d, bb);
    spam(1'b1, DIDC, A_STAT, 32'h0, d, bb);
    n_cmp++;
    if (d !== 32'h0001_0000) begin
      n_mis++;
      $display("FAIL txovf_clear got %h want 00010000", d);
    end
  endtask

  task automatic test_rx_basic();
    logic [31:0] d;
    logic [31:0] e;
    logic bb;
    @(negedge clk);
    bus.sys_rx_data  = 8'h0D;
    bus.sys_rx_valid = 1'b1;
    @(negedge clk);
    bus.sys_rx_valid = 1'b0;
    spam(1'b1, DIDC, A_DATA, 32'h0, d, bb);
    e = (rxq.size() != 0) ? {23'h0, 1'b1, rxq.pop_front()} : 32'h0;
    n_cmp++;
    if (d !== e || e !== 32'h0000_010D || bb !== 1'b1) begin
      n_mis++;
      $display("FAIL rx_read got %h/%b want 0000010d/1", d, bb);
    end
    spam(1'b1, DIDC, A_DATA, 32'h0, d, bb);
    n_cmp++;
    if (d !== 32'h0 || bb !== 1'b1) begin
      n_mis++;
      $display("FAIL rx_empty_read got %h/%b want 0/1", d, bb);
    end
  endtask

  task automatic test_rx_full_wrap();
    logic [31:0] d;
    logic [31:0] e;
    logic bb;
    int n;
    n = 0;
    @(negedge clk);
    bus.sys_rx_data  = 8'h80;
    bus.sys_rx_valid = 1'b1;
    while (rxq.size() < 16 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      bus.sys_rx_data = 8'h80 + 8'(n);
    end
    n_cmp++;
    if (rxq.size() != 16) begin
      n_mis++;
      $display("FAIL rx_fill got %0d want 16", rxq.size());
    end
    bus.sys_rx_data = 8'hEE;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.sys_rx_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL rx_full_ready got %b want 0", bus.sys_rx_ready);
    end
    spam(1'b1, DIDC, A_STAT, 32'h0, d, bb);
    n_cmp++;
    if (d !== 32'h0008_0010) begin
      n_mis++;
      $display("FAIL rx_full_status got %h want 00080010", d);
    end
    spam(1'b1, DIDC, A_DATA, 32'h0, d, bb);
    e = (rxq.size() != 0) ? {23'h0, 1'b1, rxq.pop_front()} : 32'h0;
    n_cmp++;
    if (d !== e || d !== 32'h0000_0180) begin
      n_mis++;
      $display("FAIL rx_full_pop got %h want 00000180", d);
    end
    @(posedge clk);
    #1;
    bus.sys_rx_valid = 1'b0;
    spam(1'b1, DIDC, A_STAT, 32'h0, d, bb);
    n_cmp++;
    if (d !== 32'h0008_0010) begin
      n_mis++;
      $display("FAIL rx_refill_status got %h want 00080010", d);
    end
    for (int i = 0; i < 16; i++) begin
      spam(1'b1, DIDC, A_DATA, 32'h0, d, bb);
      e = (rxq.size() != 0) ? {23'h0, 1'b1, rxq.pop_front()} : 32'h0;
      n_cmp++;
      if (d !== e || e === 32'h0) begin
        n_mis++;
        $display("FAIL rx_wrap_%0d got %h want %h", i, d, e);
      end
    end
    spam(1'b0, DIDC, A_STAT, 32'h1, d, bb);
    spam(1'b1, DIDC, A_STAT, 32'h0, d, bb);
    n_cmp++;
    if (d !== 32'h0001_0000) begin
      n_mis++;
      $display("FAIL rx_clear got %h want 00010000", d);
    end
  endtask

  task automatic test_unselected();
    logic [31:0] d;
    logic bb;
    spam(1'b0, DIDC + 4'h1, A_DATA, 32'h55, d, bb);
    n_cmp++;
    if (bb !== 1'b0 || d !== 32'h0) begin
      n_mis++;
      $display("FAIL nosel_wr got %b/%h want 0/0", bb, d);
    end
    spam(1'b1, DIDC ^ 4'h4, A_STAT, 32'h0, d, bb);
    n_cmp++;
    if (bb !== 1'b0 || d !== 32'h0) begin
      n_mis++;
      $display("FAIL nosel_rd got %b/%h want 0/0", bb, d);
    end
    spam(1'b0, DIDC, A_R2, 32'hFF, d, bb);
    spam(1'b1, DIDC, A_R2, 32'h0, d, bb);
    n_cmp++;
    if (bb !== 1'b1 || d !== 32'h0) begin
      n_mis++;
      $display("FAIL idx2_rd got %b/%h want 1/0", bb, d);
    end
    spam(1'b1, DIDC, A_STAT, 32'h0, d, bb);
    n_cmp++;
    if (d !== 32'h0001_0000 || bus.sys_tx_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL nosel_status got %h want 00010000", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic bb;
    wr_tx(8'hA1, 1'b0);
    wr_tx(8'hA2, 1'b0);
    wr_tx(8'hA3, 1'b0);
    @(negedge clk);
    bus.sys_rx_data  = 8'h33;
    bus.sys_rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus.sys_rx_valid = 1'b0;
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.sys_rx_ready !== 1'b0 || bus.sys_tx_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL midrst got rdy/vld %b/%b want 0/0",
               bus.sys_rx_ready, bus.sys_tx_valid);
    end
    @(negedge clk);
    rst_b = 1'b1;
    rxq.delete();
    txq.delete();
    spam(1'b1, DIDC, A_STAT, 32'h0, d, bb);
    n_cmp++;
    if (d !== 32'h0001_0000) begin
      n_mis++;
      $display("FAIL midrst_status got %h want 00010000", d);
    end
    spam(1'b1, DIDC, A_DATA, 32'h0, d, bb);
    n_cmp++;
    if (d !== 32'h0) begin
      n_mis++;
      $display("FAIL midrst_rx got %h want 0", d);
    end
  endtask

  initial begin
    bus.spamo_valid  = 1'b0;
    bus.spamo_r_nw   = 1'b0;
    bus.spamo_did    = '0;
    bus.spamo_addr   = '0;
    bus.spamo_data   = '0;
    bus.sys_tx_ready = 1'b0;
    bus.sys_rx_data  = '0;
    bus.sys_rx_valid = 1'b0;
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx_basic();
    test_rx_full_wrap();
    test_unselected();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/spam_console_fifo.md
# spam_console_fifo

Parametrised SPAM-bus console slave with independent transmit and receive byte FIFOs, a status/control register and sticky overflow flags. It replaces the single-byte, one-deep console device on the SPAM bus. It decouples CPU console traffic from the system-side byte stream using valid/ready handshakes in both directions.

## Interface

Parameters:
- `DEPTH`, 16: entries per FIFO; power of two, 2..256.
- `DID`, `SPAM_DID_CONSOLE`: SPAM device ID this block answers to.
- `CW`, `$clog2(DEPTH)+1`: occupancy count width (derived; do not override).

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `rst_b`  in  1  synchronous, active-low reset.
- `spamo_valid`  in  1  SPAM request strobe.
- `spamo_r_nw`  in  1  1 = read, 0 = write.
- `spamo_did`  in  `SPAM_DID_HI+1`  target device ID.
- `spamo_addr`  in  `SPAM_ADDR_HI+1`  register byte address.
- `spamo_data`  in  `SPAM_DATA_HI+1`  write data.
- `cio__spami_busy_b`  out  1  response strobe; registered.
- `cio__spami_data`  out  `SPAM_DATA_HI+1`  read response; registered.
- `sys_tx_data`  out  8  byte toward host/terminal.
- `sys_tx_valid`  out  1  TX FIFO non-empty.
- `sys_tx_ready`  in  1  system consumes the byte when valid && ready.
- `sys_rx_data`  in  8  byte from host/terminal.
- `sys_rx_valid`  in  1  system offers a byte.
- `sys_rx_ready`  out  1  RX FIFO not full.

## Operation

- Selection: `sel = spamo_valid && spamo_did == DID`. The register index is `spamo_addr[3:2]`. Other address bits are ignored.
- Index 0, DATA:
  - Write pushes `spamo_data[7:0]` into TX.
  - Read pops RX and returns `{23'h0, 1'b1, byte}`. If RX is empty, it returns 0 and does not pop.
- Index 1, STATUS (read):
  - `[7:0]` rx_count, zero-extended from CW.
  - `[15:8]` tx_count.
  - `[16]` rx_empty; `[17]` tx_full; `[18]` tx_ovf; `[19]` rx_ovf.
  - All other bits are 0.
- Index 1, write: `spamo_data[0]` = 1 clears both overflow flags. Other bits are ignored.
- Index 2/3: reads return 0 and writes are ignored. These indices still respond.
- tx_ovf sets on a DATA write while TX is full and no same-cycle pop occurs; the byte is dropped.
- rx_ovf sets when `sys_rx_valid && !sys_rx_ready`; the byte is ignored and the system may hold it.
- A clear and a set of an overflow flag in the same cycle: set wins.
- Status counts reflect FIFO state before the current cycle's pushes and pops.
- Non-selected cycles produce `busy_b` = 0 and data = 0 on the next cycle.

## Timing

- Reset (`rst_b` = 0 at a clk edge):
  - Both FIFOs empty, pointers 0, flags 0.
  - `cio__spami_busy_b` = 0, `cio__spami_data` = 0.
  - `sys_tx_valid` = 0, `sys_rx_ready` = 0 during reset, then 1 on the first cycle out of reset.
  - A reset mid-traffic discards all FIFO contents.
- Response latency is 1 cycle: a request sampled at edge N yields `busy_b` = 1 and data valid for the cycle after edge N. No wait states.
- DATA read pop: the read data comes from the RX head at edge N, and the pop happens at edge N.
- `sys_tx_data` is the TX head, driven combinationally from FIFO RAM.
- `sys_tx_valid` and `sys_rx_ready` depend only on registered counts.
- Simultaneous push and pop:
  - Full FIFO: both occur if the pop is valid, and the count is unchanged.
  - Empty FIFO: only the push occurs. No fall-through.
- Pointers are CW-1 bits and wrap modulo DEPTH. Count is CW bits and saturates by construction at DEPTH.

## Structure

- `spam_defines.vh` holds `SPAM_*_HI`, `SPAM_DID_CONSOLE`, and new constants `SPAM_CIO_REG_DATA` = 0 and `SPAM_CIO_REG_STATUS` = 1.
- Sub-module `spam_byte_fifo` (parameter `DEPTH`):
  - Synchronous active-low reset.
  - push/pop, full/empty, count.
  - Head data is combinational.
  - Instantiated twice, once for TX and once for RX.
- The top level contains decode, the flags and the registered response.

## Test plan

- Reset, then read STATUS → `32'h0001_0000` (rx_empty only); `sys_tx_valid` = 0, `sys_rx_ready` = 1.
- Write DATA `0x41`, `0x42` with `sys_tx_ready` = 0 → STATUS tx_count = 2. Then raise ready → `sys_tx_data` shows 0x41, then 0x42 on consecutive cycles, then `sys_tx_valid` = 0.
- DEPTH = 16: write 17 bytes with ready = 0 → tx_full = 1, tx_ovf = 1, tx_count = 16. Drain → exactly the first 16 bytes appear. Write STATUS bit0 = 1 → tx_ovf = 0.
- Drive `sys_rx_valid` with `0x0D` → DATA read returns `0x0000_010D`, and the next DATA read returns `0x0000_0000`.
- Fill RX to 16 and hold valid → `sys_rx_ready` = 0, rx_ovf = 1. A DATA read and an RX push in the same cycle → rx_count stays at 16 and order is preserved across pointer wrap.
- Request with `spamo_did` ≠ DID → `busy_b` = 0, no FIFO change. Assert `rst_b` = 0 for one cycle mid-stream → all counts return to 0.
